// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the MIPS register bank.
package reg_bank_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // True when exactly one bit of the load vector is set
  function automatic logic is_onehot(input logic [NUM_REGS-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + int'(vec[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/reg_bank_read_port.sv
// One combinational read port of the register bank with write-through bypass.
module reg_bank_read_port
  import reg_bank_pkg::*;
#(
  parameter int DATA_W    = reg_bank_pkg::DATA_W,
  parameter int NUM_REGS  = reg_bank_pkg::NUM_REGS,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic [DATA_W-1:0]   i_regs [NUM_REGS],
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_byp_vld,
  input  logic [NUM_REGS-1:0] i_load,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_data
);

  logic w_is_zero;
  logic w_hit;

  assign w_is_zero = (ZERO_REG0 != 0) && (i_addr == REG_ZERO);
  // i_byp_vld already folds in reset, regWrite and the one-hot check
  assign w_hit     = (BYPASS != 0) && i_byp_vld && i_load[i_addr] && !w_is_zero;

  // Select zero, in-flight write data, or stored contents
  always_comb begin
    o_data = i_regs[i_addr];
    if (w_is_zero) begin
      o_data = '0;
    end else if (w_hit) begin
      o_data = i_wdata;
    end
  end

endmodule

// File: rtl/reg_bank.sv
// 32 x 32-bit register bank: one-hot write, two bypassed read ports,
// a stored-state debug port and a sticky illegal-load flag.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int DATA_W    = reg_bank_pkg::DATA_W,
  parameter int NUM_REGS  = reg_bank_pkg::NUM_REGS,
  parameter int ZERO_REG0 = 1,
  parameter int BYPASS    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_REGS-1:0] regLoad,
  input  logic                regWrite,
  input  logic [DATA_W-1:0]   writeData,
  input  logic [ADDR_W-1:0]   readAddr1,
  input  logic [ADDR_W-1:0]   readAddr2,
  output logic [DATA_W-1:0]   readData1,
  output logic [DATA_W-1:0]   readData2,
  input  logic [ADDR_W-1:0]   dbgAddr,
  output logic [DATA_W-1:0]   dbgData,
  output logic                loadErr
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_load_err;

  logic w_onehot;
  logic w_multi;
  logic w_byp_vld;

  assign w_onehot  = is_onehot(regLoad);
  assign w_multi   = (|regLoad) && !w_onehot;
  // Bypass only for a write that will really land this edge
  assign w_byp_vld = rst_n && regWrite && w_onehot;

  // Storage update: reset clears all, otherwise a gated one-hot write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_load_err <= 1'b0;
    end else if (regWrite) begin
      if (w_onehot) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (regLoad[i] && !((ZERO_REG0 != 0) && (i == 0))) begin
            r_regs[i] <= writeData;
          end
        end
      end
      if (w_multi) begin
        r_load_err <= 1'b1;
      end
    end
  end

  reg_bank_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG0(ZERO_REG0),
    .BYPASS   (BYPASS)
  ) u_rd_rs (
    .i_regs   (r_regs),
    .i_addr   (readAddr1),
    .i_byp_vld(w_byp_vld),
    .i_load   (regLoad),
    .i_wdata  (writeData),
    .o_data   (readData1)
  );

  reg_bank_read_port #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ZERO_REG0(ZERO_REG0),
    .BYPASS   (BYPASS)
  ) u_rd_rt (
    .i_regs   (r_regs),
    .i_addr   (readAddr2),
    .i_byp_vld(w_byp_vld),
    .i_load   (regLoad),
    .i_wdata  (writeData),
    .o_data   (readData2)
  );

  // Debug view of stored state only, never bypassed
  always_comb begin
    dbgData = r_regs[dbgAddr];
    if ((ZERO_REG0 != 0) && (dbgAddr == REG_ZERO)) begin
      dbgData = '0;
    end
  end

  assign loadErr = r_load_err;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank with hand-computed expected values.
module tb_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [31:0] regLoad;
  logic        regWrite;
  logic [31:0] writeData;
  logic [4:0]  readAddr1;
  logic [4:0]  readAddr2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;
  logic        loadErr;

  int total;
  int bad;

  reg_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .regLoad  (regLoad),
    .regWrite (regWrite),
    .writeData(writeData),
    .readAddr1(readAddr1),
    .readAddr2(readAddr2),
    .readData1(readData1),
    .readData2(readData2),
    .dbgAddr  (dbgAddr),
    .dbgData  (dbgData),
    .loadErr  (loadErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] ld, input logic [31:0] wd);
    regWrite  = wr;
    regLoad   = ld;
    writeData = wd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbgAddr = a;
    #1;
    chk(tag, dbgData, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    readAddr1 = 5'd0;
    readAddr2 = 5'd0;
    dbgAddr   = 5'd0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset clears a previously written register
    drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    tick();
    idle();
    dbg_chk("pre_rst_r5", 5'd5, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      dbg_chk($sformatf("rst_r%0d", a), 5'(a), 32'h0);
    end
    chk("rst_loadErr", {31'h0, loadErr}, 32'h0);

    // Basic write then read on both ports
    drive(1'b1, 32'h0000_0100, 32'h1234_5678);
    tick();
    idle();
    readAddr1 = 5'd8;
    readAddr2 = 5'd8;
    #1;
    chk("wr_rd1_r8", readData1, 32'h1234_5678);
    chk("wr_rd2_r8", readData2, 32'h1234_5678);
    for (int a = 0; a < 32; a++) begin
      if (a != 8) dbg_chk($sformatf("wr_other_r%0d", a), 5'(a), 32'h0);
    end

    // regWrite gating, including a multi-hot vector
    drive(1'b0, 32'h0000_0010, 32'hFFFF_FFFF);
    tick();
    dbg_chk("gate_r4", 5'd4, 32'h0);
    drive(1'b0, 32'h0000_00F0, 32'hFFFF_FFFF);
    tick();
    idle();
    #1;
    chk("gate_multi_noerr", {31'h0, loadErr}, 32'h0);
    dbg_chk("gate_multi_r5", 5'd5, 32'h0);

    // Zero register: no bypass, no store
    drive(1'b1, 32'h0000_0001, 32'hAAAA_AAAA);
    readAddr1 = 5'd0;
    #1;
    chk("zero_rd1_same", readData1, 32'h0);
    tick();
    idle();
    #1;
    chk("zero_rd1_after", readData1, 32'h0);

    // regWrite with empty vector: no-op, no error
    drive(1'b1, 32'h0, 32'hCAFE_F00D);
    tick();
    idle();
    #1;
    chk("empty_noerr", {31'h0, loadErr}, 32'h0);

    // Bypass on both ports; debug shows old value until the edge
    drive(1'b1, 32'h0000_0008, 32'h0000_0011);
    tick();
    drive(1'b1, 32'h0000_0008, 32'h0000_0022);
    readAddr1 = 5'd3;
    readAddr2 = 5'd3;
    dbgAddr   = 5'd3;
    #1;
    chk("byp_rd1", readData1, 32'h0000_0022);
    chk("byp_rd2", readData2, 32'h0000_0022);
    chk("byp_dbg_old", dbgData, 32'h0000_0011);
    tick();
    idle();
    #1;
    chk("byp_dbg_new", dbgData, 32'h0000_0022);
    chk("byp_rd1_stored", readData1, 32'h0000_0022);

    // Illegal multi-hot load
    drive(1'b1, 32'h0000_0002, 32'h0000_0101);
    tick();
    drive(1'b1, 32'h0000_0004, 32'h0000_0202);
    tick();
    drive(1'b1, 32'h0000_0006, 32'h5555_5555);
    readAddr1 = 5'd1;
    readAddr2 = 5'd2;
    #1;
    chk("ill_rd1_nobyp", readData1, 32'h0000_0101);
    chk("ill_rd2_nobyp", readData2, 32'h0000_0202);
    chk("ill_err_before", {31'h0, loadErr}, 32'h0);
    tick();
    idle();
    dbg_chk("ill_r1", 5'd1, 32'h0000_0101);
    dbg_chk("ill_r2", 5'd2, 32'h0000_0202);
    chk("ill_err_set", {31'h0, loadErr}, 32'h1);
    drive(1'b1, 32'h0000_0200, 32'h0000_0099);
    tick();
    idle();
    dbg_chk("ill_legal_r9", 5'd9, 32'h0000_0099);
    chk("ill_err_sticky", {31'h0, loadErr}, 32'h1);

    // Reset wins over a simultaneous write; bypass suppressed
    rst_n = 1'b0;
    drive(1'b1, 32'h8000_0000, 32'h7777_7777);
    readAddr1 = 5'd31;
    readAddr2 = 5'd9;
    #1;
    chk("rstw_rd1_same", readData1, 32'h0);
    chk("rstw_rd2_r9_stored", readData2, 32'h0000_0099);
    tick();
    idle();
    rst_n = 1'b1;
    dbg_chk("rstw_r31", 5'd31, 32'h0);
    dbg_chk("rstw_r9", 5'd9, 32'h0);
    chk("rstw_err_clr", {31'h0, loadErr}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
